ring_outport_arbiter: RTL and testbench
=======================================

# ring_outport_arbiter

Output-port controller for one ring direction (cw or ccw) of a ring router node. Generates the node's even/odd polarity phase and holds a one-entry output buffer per virtual channel (VC). Each cycle it arbitrates, round-robin, between pass-through traffic and local PE injection for the internal phase's buffer, while the external phase's buffer drives the inter-node link with a send/ready handshake. One instance per direction per router; the ring-level top is unchanged.

## Interface
- DATA_W, 64: packet width.
- VC_BIT, 63: index of the packet's VC bit.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fwd_req  in  1  pass-through packet from the opposite input buffer is valid.
- fwd_data  in  DATA_W  pass-through packet.
- fwd_gnt  out  1  fwd packet accepted this cycle (combinational).
- pe_req  in  1  local PE injection valid.
- pe_data  in  DATA_W  PE packet.
- pe_gnt  out  1  PE packet accepted this cycle (combinational).
- so  out  1  link send, valid toward the downstream node.
- do  out  DATA_W  link data.
- ri  in  1  downstream node ready.
- polarity  out  1  current phase, registered.

## Operation
- State: polarity flop; buf[0..1] (DATA_W) with full[0..1]; rr[0..1], one round-robin pointer per VC (0 = fwd preferred, 1 = pe preferred).
- Phase p = polarity. polarity toggles every cycle after reset is released.
- Link side, VC p:
  - so = full[p]; do = buf[p].
  - On the edge where so & ri, full[p] clears. do holds its last value until overwritten.
- Internal side, VC q = ~p:
  - A requester is eligible if its req is high, its data[VC_BIT] == q, and !full[q].
  - Requests whose VC bit equals p are ignored this cycle. The requester holds the packet and retries next phase.
  - One eligible requester: it is granted.
  - Two eligible requesters: grant the one rr[q] points to.
  - Grant: gnt high the same cycle; buf[q] <= granted data and full[q] <= 1 at the edge; rr[q] <= the non-granted source. rr[q] is unchanged when nothing is granted.
- fwd_gnt and pe_gnt are never both high. gnt is never high without the matching req.
- Drain and fill never target the same buffer in one cycle, so there is no read/write conflict.
- Requesters must hold req and data stable until granted. Dropping req before grant is legal and nothing is lost.

## Timing
- Reset (reset = 0, asynchronous) clears:
  - polarity = 0, full = 00, buf = 0, rr = 00.
  - Outputs: so = 0, do = 0, fwd_gnt = 0, pe_gnt = 0.
- Reset asserted mid-transfer drops any buffered packet. No partial state survives.
- First edge after release: polarity becomes 1.
- Latency, grant to link:
  - A packet granted in phase q appears on so/do on the next edge, when polarity == q.
  - Minimum 1 cycle, if ri = 1.
- Backpressure: if ri = 0, full[p] stays set. That VC refills no earlier than after the drain completes, plus up to 2 cycles of phase wait.
- Full throughput: one packet per cycle across both VCs, alternating VCs.

## Structure
- Shared ring package holds:
  - DATA_W and VC_BIT.
  - Requester encoding constants (RR_FWD = 0, RR_PE = 1).
  - Packet field offsets (VC bit, direction bit, hop count at [55:48]) used by the router and the bench.
- One sub-module, rr_arb2: 2-request round-robin arbiter with a pointer input and one-hot grant output, instantiated once per VC.

## Test plan
- Reset release:
  - Check so = 0, do = 0, polarity = 0 during reset.
  - Check polarity toggles 1, 0, 1 on successive edges.
- Single PE packet, no contention:
  - At polarity = 1, drive pe_req with pe_data = 64'h0000_0000_0000_00A5 (VC 0).
  - Expect pe_gnt the same cycle, then so = 1 and do = ...A5 in the next cycle (polarity = 0), ri = 1.
  - Expect so = 0 after.
- Contention fairness:
  - Hold fwd_req and pe_req continuously, both VC 1, ri = 1.
  - Expect grants to alternate fwd, pe, fwd, pe on successive polarity = 0 cycles.
  - Expect never a double grant.
- Wrong-phase request:
  - Drive a VC 0 request while polarity = 0.
  - Expect no grant that cycle, and a grant on the following cycle.
- Backpressure:
  - Fill VC 0, hold ri = 0 for 6 cycles.
  - Expect so = 1 only in polarity = 0 cycles, and do stable.
  - Expect further VC 0 requests not granted.
  - Release ri and expect the drain then a new grant within 2 cycles.
- Mid-operation reset:
  - Assert reset with both buffers full.
  - Expect so = 0 and full = 00 immediately (asynchronous), and no stale packet after release.

Source files
------------

// File: rtl/ring_outport_arbiter_pkg.sv
// Shared ring definitions: packet width, packet field offsets and the
// round-robin requester encoding used by the output-port arbiter and
// its testbench.
package ring_outport_arbiter_pkg;

  localparam int DATA_W  = 64;

  // Packet field offsets
  localparam int VC_BIT  = 63;  // virtual channel (0 = even, 1 = odd)
  localparam int DIR_BIT = 62;  // ring direction
  localparam int HOP_MSB = 55;  // hop count [55:48]
  localparam int HOP_LSB = 48;

  // Round-robin pointer values: which requester wins a tie
  localparam logic RR_FWD = 1'b0;
  localparam logic RR_PE  = 1'b1;

  // Bit positions of each requester in the arbiter request/grant vectors
  localparam int SRC_FWD = 0;
  localparam int SRC_PE  = 1;

  function automatic logic pkt_vc(input logic [DATA_W-1:0] pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/ring_outport_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
// Ports:
//   req_i  [1:0]  request vector, bit SRC_FWD = fwd, bit SRC_PE = pe
//   ptr_i         tie-break pointer (RR_FWD or RR_PE)
//   gnt_o  [1:0]  one-hot grant (all zero when nothing requests)
module rr_arb2
  import ring_outport_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    // Only a tie needs the pointer; a lone request is granted directly.
    if (req_i == 2'b11) begin
      gnt_o = (ptr_i == RR_FWD) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/ring_outport_arbiter.sv
// Output-port controller for one ring direction of a router node.
// Generates the even/odd polarity phase and keeps a one-entry buffer per
// virtual channel. The buffer whose VC equals the current polarity drives
// the link; the other buffer is filled from pass-through (fwd) or local
// PE traffic using a per-VC round-robin arbiter.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   fwd_req_i/fwd_data_i/fwd_gnt_o   pass-through request, packet, grant
//   pe_req_i/pe_data_i/pe_gnt_o      PE injection request, packet, grant
//   so_o/do_o/ri_i             link send, link data, downstream ready
//   polarity_o                 current phase (registered)
//   full_o                     debug view of the per-VC buffer-full flags
// Handshake: a requester holds req and data stable until gnt is seen high
// in the same cycle (gnt is combinational); the link transfers a packet on
// every rising edge where so_o and ri_i are both high.
module ring_outport_arbiter
  import ring_outport_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fwd_req_i,
  input  logic [DATA_W-1:0] fwd_data_i,
  output logic              fwd_gnt_o,
  input  logic              pe_req_i,
  input  logic [DATA_W-1:0] pe_data_i,
  output logic              pe_gnt_o,
  output logic              so_o,
  output logic [DATA_W-1:0] do_o,
  input  logic              ri_i,
  output logic              polarity_o,
  output logic [1:0]        full_o
);

  logic              polarity_q, polarity_d;
  logic [1:0]        full_q, full_d;
  logic [1:0]        rr_q, rr_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];

  logic p;   // VC on the link this cycle
  logic q;   // VC being filled this cycle
  assign p = polarity_q;
  assign q = ~polarity_q;

  logic [1:0][1:0] gnt_vc;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [1:0] req;
    // Only the internal-phase VC may be filled; requests for the link-phase
    // VC simply wait until the phase flips.
    assign req[SRC_FWD] = fwd_req_i && (pkt_vc(fwd_data_i) == 1'(v))
                          && (q == 1'(v)) && !full_q[v];
    assign req[SRC_PE]  = pe_req_i && (pkt_vc(pe_data_i) == 1'(v))
                          && (q == 1'(v)) && !full_q[v];

    rr_arb2 u_arb (
      .req_i (req),
      .ptr_i (rr_q[v]),
      .gnt_o (gnt_vc[v])
    );
  end

  // Grants are forced low while reset is held so no packet is consumed
  // into state that reset is about to discard.
  assign fwd_gnt_o = reset & gnt_vc[q][SRC_FWD];
  assign pe_gnt_o  = reset & gnt_vc[q][SRC_PE];

  assign so_o       = full_q[p];
  assign do_o       = buf_q[p];
  assign polarity_o = polarity_q;
  assign full_o     = full_q;

  always_comb begin
    polarity_d = ~polarity_q;
    full_d     = full_q;
    buf_d      = buf_q;
    rr_d       = rr_q;

    // Drain and fill address different VCs (p vs q), so they never collide.
    if (full_q[p] && ri_i) begin
      full_d[p] = 1'b0;
    end

    if (fwd_gnt_o || pe_gnt_o) begin
      full_d[q] = 1'b1;
      buf_d[q]  = fwd_gnt_o ? fwd_data_i : pe_data_i;
      rr_d[q]   = fwd_gnt_o ? RR_PE : RR_FWD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity_q <= 1'b0;
      full_q     <= 2'b00;
      rr_q       <= 2'b00;
      buf_q      <= '{default: '0};
    end else begin
      polarity_q <= polarity_d;
      full_q     <= full_d;
      rr_q       <= rr_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_ring_outport_arbiter.sv
module tb_ring_outport_arbiter;
  import ring_outport_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              fwd_req_i = 1'b0;
  logic [DATA_W-1:0] fwd_data_i = '0;
  logic              fwd_gnt_o;
  logic              pe_req_i = 1'b0;
  logic [DATA_W-1:0] pe_data_i = '0;
  logic              pe_gnt_o;
  logic              so_o;
  logic [DATA_W-1:0] do_o;
  logic              ri_i = 1'b1;
  logic              polarity_o;
  logic [1:0]        full_o;

  ring_outport_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .fwd_req_i  (fwd_req_i),
    .fwd_data_i (fwd_data_i),
    .fwd_gnt_o  (fwd_gnt_o),
    .pe_req_i   (pe_req_i),
    .pe_data_i  (pe_data_i),
    .pe_gnt_o   (pe_gnt_o),
    .so_o       (so_o),
    .do_o       (do_o),
    .ri_i       (ri_i),
    .polarity_o (polarity_o),
    .full_o     (full_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  // Expected packets waiting on each VC's link, in send order.
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic [DATA_W-1:0] m_last [2];   // last packet written into each VC buffer
  bit                m_pol = 1'b0;
  bit                m_pref [2];   // 0: fwd wins a tie, 1: pe wins
  bit                g_fwd = 1'b0; // model granted fwd in the cycle just ended
  bit                g_pe  = 1'b0;
  int                n_fwd_g = 0;
  int                n_pe_g  = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check64(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic int qsize(input bit vc);
    return vc ? exp_q1.size() : exp_q0.size();
  endfunction

  // ---------------- reference model + monitor ----------------
  // Evaluated mid-cycle: inputs are stable, outputs are compared against
  // the model, then the model commits what the coming edge will do.
  bit mp, mq, exp_so, fe, pe_e, ef, ep;
  logic [DATA_W-1:0] front;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q0.delete();
      exp_q1.delete();
      m_last[0] = '0;
      m_last[1] = '0;
      m_pref[0] = 1'b0;
      m_pref[1] = 1'b0;
      m_pol = 1'b0;
      g_fwd = 1'b0;
      g_pe  = 1'b0;
      check1("rst_so", so_o, 1'b0);
      check64("rst_do", do_o, '0);
      check1("rst_polarity", polarity_o, 1'b0);
      check1("rst_fwd_gnt", fwd_gnt_o, 1'b0);
      check1("rst_pe_gnt", pe_gnt_o, 1'b0);
    end else begin
      mp = m_pol;
      mq = ~m_pol;
      exp_so = (qsize(mp) != 0);
      check1("polarity", polarity_o, mp);
      check1("so", so_o, exp_so);
      if (exp_so) begin
        front = mp ? exp_q1[0] : exp_q0[0];
        check64("do_pkt", do_o, front);
      end else begin
        check64("do_hold", do_o, m_last[mp]);
      end

      fe   = fwd_req_i && (fwd_data_i[VC_BIT] == mq) && (qsize(mq) == 0);
      pe_e = pe_req_i  && (pe_data_i[VC_BIT]  == mq) && (qsize(mq) == 0);
      ef = fe && (!pe_e || !m_pref[mq]);
      ep = pe_e && !ef;
      check1("fwd_gnt", fwd_gnt_o, ef);
      check1("pe_gnt", pe_gnt_o, ep);

      if (exp_so && ri_i) begin
        if (mp) void'(exp_q1.pop_front());
        else    void'(exp_q0.pop_front());
      end
      if (ef || ep) begin
        front = ef ? fwd_data_i : pe_data_i;
        if (mq) exp_q1.push_back(front);
        else    exp_q0.push_back(front);
        m_last[mq] = front;
        m_pref[mq] = ef;
        if (ef) n_fwd_g++;
        else    n_pe_g++;
      end
      g_fwd = ef;
      g_pe  = ep;
      m_pol = ~mp;
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one cycle; a requester that the model saw granted drops its req.
  task automatic step();
    @(posedge clk);
    #1;
    if (g_fwd) fwd_req_i = 1'b0;
    if (g_pe)  pe_req_i  = 1'b0;
  endtask

  task automatic wait_pol(input logic v);
    for (int i = 0; i < 4 && polarity_o !== v; i++) step();
    check1("wait_polarity", polarity_o, v);
  endtask

  // ---------------- stimulus ----------------
  int base_f, base_p, k;
  bit fair;

  initial begin
    // Reset held for two edges, then released: polarity 1, 0, 1, ...
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (4) step();

    // Single PE packet on VC 0 with no contention
    ri_i = 1'b1;
    wait_pol(1'b1);
    base_p = n_pe_g;
    pe_req_i  = 1'b1;
    pe_data_i = 64'h0000_0000_0000_00A5;
    step();
    repeat (3) step();
    check1("single_pe_granted", (n_pe_g - base_p) == 1, 1'b1);

    // Contention fairness on VC 1
    base_f = n_fwd_g;
    base_p = n_pe_g;
    for (int i = 0; i < 16; i++) begin
      if (!fwd_req_i) begin
        fwd_req_i  = 1'b1;
        fwd_data_i = {1'b1, 15'h0F0F, 8'(i), 8'h00, 32'($urandom)};
      end
      if (!pe_req_i) begin
        pe_req_i  = 1'b1;
        pe_data_i = {1'b1, 15'h7E7E, 8'(i), 8'h11, 32'($urandom)};
      end
      step();
    end
    fwd_req_i = 1'b0;
    pe_req_i  = 1'b0;
    fair = ((n_fwd_g - base_f) == (n_pe_g - base_p)) && ((n_fwd_g - base_f) >= 3);
    check1("contention_fair", fair, 1'b1);
    repeat (3) step();

    // Wrong-phase request: VC 0 offered while polarity = 0
    wait_pol(1'b0);
    base_f = n_fwd_g;
    fwd_req_i  = 1'b1;
    fwd_data_i = 64'h0000_0000_0000_0123;
    step();
    check1("wrong_phase_held", fwd_req_i, 1'b1);
    step();
    check1("wrong_phase_next", (n_fwd_g - base_f) == 1, 1'b1);
    repeat (2) step();

    // Backpressure on VC 0
    ri_i = 1'b0;
    wait_pol(1'b1);
    pe_req_i  = 1'b1;
    pe_data_i = 64'h0000_0000_0000_BEEF;
    step();
    fwd_req_i  = 1'b1;
    fwd_data_i = 64'h0000_0000_0000_CAFE;
    base_f = n_fwd_g;
    repeat (6) step();
    check1("bp_no_grant", n_fwd_g == base_f, 1'b1);
    ri_i = 1'b1;
    k = 0;
    while (k < 4 && fwd_req_i) begin
      step();
      k++;
    end
    check1("bp_regrant", fwd_req_i, 1'b0);
    repeat (2) step();

    // Mid-operation reset with both buffers full
    ri_i = 1'b0;
    wait_pol(1'b1);
    pe_req_i  = 1'b1;
    pe_data_i = 64'h0000_0000_0000_1111;
    step();
    pe_req_i  = 1'b1;
    pe_data_i = 64'h8000_0000_0000_2222;
    step();
    check64("pre_reset_full", 64'(full_o), 64'd3);
    reset = 1'b0;
    #1;
    check1("async_rst_so", so_o, 1'b0);
    check64("async_rst_full", 64'(full_o), 64'd0);
    @(posedge clk);
    #1;
    pe_req_i = 1'b0;
    reset = 1'b1;
    ri_i  = 1'b1;
    repeat (6) step();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ri_i = ($urandom_range(3) != 0);
      if (fwd_req_i && $urandom_range(15) == 0) fwd_req_i = 1'b0;
      else if (!fwd_req_i && $urandom_range(1) == 1) begin
        fwd_req_i  = 1'b1;
        fwd_data_i = {$urandom, $urandom};
      end
      if (pe_req_i && $urandom_range(15) == 0) pe_req_i = 1'b0;
      else if (!pe_req_i && $urandom_range(1) == 1) begin
        pe_req_i  = 1'b1;
        pe_data_i = {$urandom, $urandom};
      end
      step();
    end
    fwd_req_i = 1'b0;
    pe_req_i  = 1'b0;
    ri_i      = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
